// File: rtl/cascaded_mod_counter_pkg.sv
// Package for the cascaded modulo-N counter.
// Contents:
//   DIR_UP / DIR_DOWN : encodings of the 'up' direction input
//   mod_fits()        : legality check that MOD digit values fit in W bits
package cnt_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // A digit must hold values 0..MOD-1, so MOD needs at least two states
    // and MOD-1 must be representable in w bits.
    function automatic bit mod_fits(input int mod, input int w);
        return (mod >= 2) && (w >= 1) && (w < 31) && (mod <= (1 << w));
    endfunction

endpackage

// File: rtl/cascaded_mod_counter_if.sv
// Control/status bundle of the cascaded modulo-N counter.
// Signals:
//   clear, load, load_val, en, up : control inputs to the counter
//   count, tc, ovf, load_err      : status outputs from the counter
// Modports:
//   master : the controlling side (drives controls, observes status)
//   slave  : the counter itself
// Protocol: there is no valid/ready handshake. Every control is a level
// sampled on each rising clk edge; count/ovf/load_err are registered and
// change one cycle after the sampling edge, tc is combinational.
interface cascaded_mod_counter_if #(
    parameter int DIGITS = 4,
    parameter int W      = 4
);
    logic                clear;
    logic                load;
    logic [DIGITS*W-1:0] load_val;
    logic                en;
    logic                up;
    logic [DIGITS*W-1:0] count;
    logic                tc;
    logic                ovf;
    logic                load_err;

    modport master (
        output clear, load, load_val, en, up,
        input  count, tc, ovf, load_err
    );

    modport slave (
        input  clear, load, load_val, en, up,
        output count, tc, ovf, load_err
    );
endinterface

// File: rtl/cascaded_mod_counter_digit.sv
// mod_digit: one W-bit modulo-MOD up/down digit.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   clear      : synchronous clear to 0
//   load       : load from load_val (clamped to MOD-1 when out of range)
//   load_val   : load data for this digit
//   step       : advance one position in direction 'up' this cycle
//   up         : 1 = increment, 0 = decrement
//   value      : current digit value, always within 0..MOD-1
//   at_max     : value == MOD-1
//   at_zero    : value == 0
//   clamped    : load_val is out of range (meaningful when load is high)
module mod_digit
    import cnt_pkg::*;
#(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    input  logic         up,
    output logic [W-1:0] value,
    output logic         at_max,
    output logic         at_zero,
    output logic         clamped
);

    localparam int         MAX_I = MOD - 1;
    localparam int         ONE_I = 1;
    localparam logic [W:0]   MOD_V = MOD[W:0];
    localparam logic [W-1:0] MAX_V = MAX_I[W-1:0];
    localparam logic [W-1:0] ONE_V = ONE_I[W-1:0];

    logic [W-1:0] value_q;

    // Extra top bit so MOD == 2**W still compares correctly.
    assign clamped = ({1'b0, load_val} >= MOD_V);
    assign at_max  = (value_q == MAX_V);
    assign at_zero = (value_q == '0);
    assign value   = value_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            value_q <= '0;
        end else if (clear) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= clamped ? MAX_V : load_val;
        end else if (step) begin
            if (up == DIR_UP) begin
                value_q <= at_max ? '0 : value_q + ONE_V;
            end else begin
                value_q <= at_zero ? MAX_V : value_q - ONE_V;
            end
        end
    end

endmodule

// File: rtl/cascaded_mod_counter.sv
// cascaded_mod_counter: DIGITS-digit modulo-MOD up/down counter
// (a BCD counter when MOD=10, W=4).
// Ports:
//   clk  : clock, all state updates on posedge
//   rstn : synchronous active-low reset
//   bus  : slave side of cascaded_mod_counter_if
//          clear/load/load_val/en/up in, count/tc/ovf/load_err out.
//          Digit i lives in bits [i*W +: W], digit 0 least significant.
// Priority each cycle: rstn > clear > load > en.
module cascaded_mod_counter
    import cnt_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int MOD    = 10,
    parameter int W      = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    cascaded_mod_counter_if.slave bus
);

    if (!mod_fits(MOD, W)) begin : g_bad_params
        $error("cascaded_mod_counter: MOD=%0d does not fit in W=%0d bits", MOD, W);
    end

    logic [DIGITS-1:0]   step;
    logic [DIGITS-1:0]   at_max;
    logic [DIGITS-1:0]   at_zero;
    logic [DIGITS-1:0]   clamped;
    logic [DIGITS-1:0]   at_limit;
    logic [DIGITS*W-1:0] count_w;
    logic                tc_w;
    logic                ovf_q;
    logic                load_err_q;

    // "At limit" means the digit is about to wrap in the current direction.
    assign at_limit = (bus.up == DIR_UP) ? at_max : at_zero;

    // Digit i steps when counting is enabled and every lower digit is at
    // its limit: an AND chain over the lower digits' limit flags.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign step[i] = bus.en;
        end else begin : g_upper
            assign step[i] = bus.en & (&at_limit[i-1:0]);
        end

        mod_digit #(
            .MOD (MOD),
            .W   (W)
        ) u_digit (
            .clk      (clk),
            .rstn     (rstn),
            .clear    (bus.clear),
            .load     (bus.load),
            .load_val (bus.load_val[i*W +: W]),
            .step     (step[i]),
            .up       (bus.up),
            .value    (count_w[i*W +: W]),
            .at_max   (at_max[i]),
            .at_zero  (at_zero[i]),
            .clamped  (clamped[i])
        );
    end

    // Terminal count: every digit at its limit while enabled. The next
    // enabled edge (with no clear/load) is a whole-counter wrap.
    assign tc_w = bus.en & (&at_limit);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else if (bus.clear) begin
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else if (bus.load) begin
            ovf_q      <= 1'b0;
            load_err_q <= |clamped;
        end else begin
            ovf_q      <= tc_w;
            load_err_q <= 1'b0;
        end
    end

    assign bus.count    = count_w;
    assign bus.tc       = tc_w;
    assign bus.ovf      = ovf_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_cascaded_mod_counter.sv
// Directed testbench for cascaded_mod_counter.
// Main instance: DIGITS=4, MOD=10, W=4 (BCD). Variant: DIGITS=2, MOD=6, W=3.
module tb_cascaded_mod_counter;

    logic clk;
    logic rstn;

    int n_vec;
    int n_err;

    logic [5:0] exp_q[$];

    cascaded_mod_counter_if #(.DIGITS(4), .W(4)) m_if ();
    cascaded_mod_counter_if #(.DIGITS(2), .W(3)) v_if ();

    cascaded_mod_counter #(.DIGITS(4), .MOD(10), .W(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (m_if.slave)
    );

    cascaded_mod_counter #(.DIGITS(2), .MOD(6), .W(3)) dut_v (
        .clk  (clk),
        .rstn (rstn),
        .bus  (v_if.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic clr, input logic ld, input logic [15:0] lv,
                           input logic e, input logic u);
        m_if.clear    = clr;
        m_if.load     = ld;
        m_if.load_val = lv;
        m_if.en       = e;
        m_if.up       = u;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_m(input string tag, input logic [15:0] cnt, input logic ovf_e,
                           input logic lerr_e);
        check({tag, " count"}, 32'(m_if.count), 32'(cnt));
        check({tag, " ovf"}, 32'(m_if.ovf), 32'(ovf_e));
        check({tag, " load_err"}, 32'(m_if.load_err), 32'(lerr_e));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [5:0] prev;
        logic [5:0] exp_c;
        int d0;
        int d1;

        n_vec = 0;
        n_err = 0;

        rstn = 1'b0;
        drive_m(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        v_if.clear    = 1'b0;
        v_if.load     = 1'b0;
        v_if.load_val = 6'o00;
        v_if.en       = 1'b0;
        v_if.up       = 1'b1;
        tick();
        tick();
        check_m("reset", 16'h0000, 1'b0, 1'b0);
        check("reset v count", 32'(v_if.count), 32'd0);
        check("reset tc (en=0)", 32'(m_if.tc), 32'd0);
        rstn = 1'b1;

        // Count up 123 times from zero -> BCD 0123.
        drive_m(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 123; i++) tick();
        check_m("count to 0123", 16'h0123, 1'b0, 1'b0);
        check("tc at 0123", 32'(m_if.tc), 32'd0);

        // Reset mid-count overrides en and load.
        rstn = 1'b0;
        drive_m(1'b0, 1'b1, 16'h5555, 1'b1, 1'b1);
        tick();
        check_m("reset mid-count", 16'h0000, 1'b0, 1'b0);
        rstn = 1'b1;

        // Up wrap.
        drive_m(1'b0, 1'b1, 16'h9998, 1'b0, 1'b1);
        tick();
        check_m("load 9998", 16'h9998, 1'b0, 1'b0);
        drive_m(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        check("tc at 9998", 32'(m_if.tc), 32'd0);
        tick();
        check_m("up 9999", 16'h9999, 1'b0, 1'b0);
        check("tc at 9999 up", 32'(m_if.tc), 32'd1);
        tick();
        check_m("up wrap 0000", 16'h0000, 1'b1, 1'b0);
        check("tc at 0000 up", 32'(m_if.tc), 32'd0);
        tick();
        check_m("up 0001", 16'h0001, 1'b0, 1'b0);

        // Borrow across three digits.
        drive_m(1'b0, 1'b1, 16'h1000, 1'b0, 1'b1);
        tick();
        drive_m(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        check_m("down 1000->0999", 16'h0999, 1'b0, 1'b0);

        // Direction change mid-count.
        drive_m(1'b0, 1'b1, 16'h0009, 1'b0, 1'b1);
        tick();
        drive_m(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        tick();
        check_m("up 0009->0010", 16'h0010, 1'b0, 1'b0);
        m_if.up = 1'b0;
        tick();
        check_m("down 0010->0009", 16'h0009, 1'b0, 1'b0);

        // Down wrap.
        drive_m(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        tick();
        drive_m(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        #1;
        check("tc at 0000 down", 32'(m_if.tc), 32'd1);
        m_if.up = 1'b1;
        #1;
        check("tc at 0000 up dir", 32'(m_if.tc), 32'd0);
        m_if.up = 1'b0;
        tick();
        check_m("down wrap 9999", 16'h9999, 1'b1, 1'b0);
        tick();
        check_m("down 9998", 16'h9998, 1'b0, 1'b0);

        // Priority: clear beats load beats en.
        drive_m(1'b1, 1'b1, 16'h5555, 1'b1, 1'b1);
        tick();
        check_m("clear over load", 16'h0000, 1'b0, 1'b0);
        drive_m(1'b0, 1'b1, 16'h4321, 1'b1, 1'b1);
        tick();
        check_m("load over en", 16'h4321, 1'b0, 1'b0);
        drive_m(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        check_m("hold en=0", 16'h4321, 1'b0, 1'b0);

        // Out-of-range load is clamped per digit.
        drive_m(1'b0, 1'b1, 16'hF3A2, 1'b0, 1'b1);
        tick();
        check_m("clamp load", 16'h9392, 1'b0, 1'b1);
        drive_m(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        check_m("load_err one cycle", 16'h9392, 1'b0, 1'b0);
        check("tc hold en=0", 32'(m_if.tc), 32'd0);
        drive_m(1'b0, 1'b1, 16'hF3A2, 1'b0, 1'b1);
        tick();
        check_m("clamp load again", 16'h9392, 1'b0, 1'b1);
        drive_m(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        check_m("clear after clamp", 16'h0000, 1'b0, 1'b0);
        drive_m(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Variant DIGITS=2, MOD=6, W=3: free-run 36 steps from 00.
        d0 = 0;
        d1 = 0;
        for (int k = 0; k < 36; k++) begin
            d0++;
            if (d0 == 6) begin
                d0 = 0;
                d1++;
                if (d1 == 6) d1 = 0;
            end
            exp_q.push_back({d1[2:0], d0[2:0]});
        end
        v_if.en = 1'b1;
        v_if.up = 1'b1;
        prev = 6'o00;
        for (int k = 0; k < 36; k++) begin
            #1;
            check("v tc", 32'(v_if.tc), 32'(prev == 6'o55));
            tick();
            exp_c = exp_q.pop_front();
            check("v count", 32'(v_if.count), 32'(exp_c));
            check("v ovf", 32'(v_if.ovf), 32'((exp_c == 6'o00) && (prev == 6'o55)));
            prev = exp_c;
        end
        v_if.en = 1'b0;
        tick();
        check("v hold after wrap", 32'(v_if.count), 32'd0);
        check("v ovf cleared", 32'(v_if.ovf), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
